// File: rtl/encoder_10_4_pkg.sv
// Shared types and constants for the 10-line one-cold to 4-bit binary encoder.
package encoder_10_4_pkg;

  localparam int LINES  = 10;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    VALID,
    RELEASE
  } state_t;

  // Index of the low line; only meaningful when exactly one bit of v_n is low.
  function automatic logic [CODE_W-1:0] cold_index(input logic [LINES-1:0] v_n);
    cold_index = '0;
    for (int i = 0; i < LINES; i++) begin
      if (!v_n[i]) cold_index = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones (lines idle).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/encoder_10_4_sync.sv
// Debounced 10-line one-cold encoder with valid/ack handshake and multi-press detection.
module encoder_10_4_sync
  import encoder_10_4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINES-1:0]  b_n,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              multi_err
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [LINES-1:0]  s_n;
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [LINES-1:0]  pat, pat_nxt;
  logic [CODE_W-1:0] idx, idx_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              valid_nxt;
  logic              multi_err_nxt;

  sync_2ff #(.WIDTH(LINES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (b_n),
    .q    (s_n)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pat_nxt       = pat;
    idx_nxt       = idx;
    code_nxt      = code;
    valid_nxt     = valid;
    multi_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (s_n != '1) begin
          if ($onehot(~s_n)) begin
            pat_nxt   = s_n;
            idx_nxt   = cold_index(s_n);
            cnt_nxt   = CNT_W'(1);
            state_nxt = DEBOUNCE;
          end else begin
            multi_err_nxt = 1'b1;
            cnt_nxt       = '0;
            state_nxt     = RELEASE;
          end
        end
      end

      DEBOUNCE: begin
        if (s_n == pat) begin
          if (cnt == CNT_LAST) begin
            code_nxt  = idx;
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = VALID;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          // A bounce silently abandons the candidate; the next sample restarts.
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end

      VALID: begin
        if (ack) begin
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      end

      RELEASE: begin
        if (s_n == '1) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pat       <= '1;
      idx       <= '0;
      code      <= '0;
      valid     <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pat       <= pat_nxt;
      idx       <= idx_nxt;
      code      <= code_nxt;
      valid     <= valid_nxt;
      multi_err <= multi_err_nxt;
    end
  end

endmodule

// File: tb/tb_encoder_10_4_sync.sv
// Self-checking bench for encoder_10_4_sync: directed presses against a behavioural model.
module tb_encoder_10_4_sync;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] b_n = 10'h3FF;
  logic       ack = 1'b0;
  logic [3:0] code;
  logic       valid;
  logic       multi_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  encoder_10_4_sync #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .b_n      (b_n),
    .ack      (ack),
    .code     (code),
    .valid    (valid),
    .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: b_n reaches the decision logic two edges late; a press
  // needs D matching samples (the capturing one included); after ack or a
  // multi-press, D consecutive quiet samples are needed before watching again.
  localparam int WATCH = 0, CONFIRM = 1, HOLD = 2, DRAIN = 3;
  logic [9:0] m_pipe1 = 10'h3FF, m_pipe2 = 10'h3FF, m_pat = 10'h3FF;
  int         m_mode = WATCH, m_run = 0, m_quiet = 0, m_line = 0;
  logic [3:0] m_code = 4'd0;
  logic       m_valid = 1'b0, m_merr = 1'b0;

  always @(posedge clk) begin
    logic [9:0] s;
    int zeros, low_line;
    if (!rst_n) begin
      m_pipe1 = 10'h3FF; m_pipe2 = 10'h3FF;
      m_mode = WATCH; m_run = 0; m_quiet = 0;
      m_code = 4'd0; m_valid = 1'b0; m_merr = 1'b0;
    end else begin
      s = m_pipe2;
      m_pipe2 = m_pipe1;
      m_pipe1 = b_n;
      m_merr = 1'b0;
      zeros = 0; low_line = 0;
      for (int i = 0; i < 10; i++) if (!s[i]) begin zeros++; low_line = i; end
      case (m_mode)
        WATCH:
          if (zeros == 1) begin
            m_pat = s; m_line = low_line; m_run = 1; m_mode = CONFIRM;
          end else if (zeros >= 2) begin
            m_merr = 1'b1; m_quiet = 0; m_mode = DRAIN;
          end
        CONFIRM:
          if (s == m_pat) begin
            m_run++;
            if (m_run == D) begin
              m_valid = 1'b1; m_code = 4'(m_line); m_mode = HOLD;
            end
          end else m_mode = WATCH;
        HOLD:
          if (ack) begin m_valid = 1'b0; m_quiet = 0; m_mode = DRAIN; end
        default:
          if (s == 10'h3FF) begin
            m_quiet++;
            if (m_quiet == D) m_mode = WATCH;
          end else m_quiet = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison plus output invariants.
  logic prev_merr = 1'b0;
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("model_valid", valid, m_valid);
      check("model_code", code, m_code);
      check("model_multi_err", multi_err, m_merr);
      check("code_range", code <= 4'd9, 1);
      check("multi_err_single", multi_err & prev_merr, 0);
    end
    prev_merr = multi_err;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges from the current negedge until valid is seen, bounded.
  task automatic wait_valid(input string name, input int exp_k, input logic [3:0] exp_code);
    int k = 0;
    while (valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, exp_k);
    check({name, "_code"}, code, exp_code);
  endtask

  task automatic ack_and_release();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_drops_valid", valid, 0);
    b_n = 10'h3FF;
    tick(8);
  endtask

  initial begin
    int merr_cycles, valid_seen, hold_ok;

    // Reset with lines idle.
    tick(3);
    check("reset_code", code, 0);
    check("reset_valid", valid, 0);
    check("reset_multi_err", multi_err, 0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    tick(2);

    // Stray ack with nothing pending is ignored.
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("stray_ack", valid, 0);

    // Press line 3, ack, quiet for 4 cycles, then line 9.
    b_n = 10'h3F7;
    wait_valid("press3", 6, 4'd3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("press3_ack", valid, 0);
    b_n = 10'h3FF;
    tick(4);
    b_n = 10'h1FF;
    wait_valid("press9", 6, 4'd9);
    ack_and_release();
    check("code_retained", code, 9);

    // Bounce on line 5: low 2, high 1, then steady low.
    b_n = 10'h3DF; tick(2);
    b_n = 10'h3FF; tick(1);
    b_n = 10'h3DF;
    wait_valid("bounce5", 6, 4'd5);
    ack_and_release();

    // Multi-press, then a single line without an intervening release.
    b_n = 10'h3FC;
    merr_cycles = 0; valid_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      merr_cycles += int'(multi_err);
      valid_seen  += int'(valid);
    end
    check("multi_err_cycles", merr_cycles, 1);
    check("multi_no_valid", valid_seen, 0);
    b_n = 10'h3FE;
    valid_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      valid_seen += int'(valid);
    end
    check("no_release_no_valid", valid_seen, 0);
    b_n = 10'h3FF;
    tick(8);

    // Hold: VALID ignores b_n changes until ack.
    b_n = 10'h3F7;
    wait_valid("hold3", 6, 4'd3);
    b_n = 10'h37F;
    hold_ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      hold_ok += int'(valid === 1'b1 && code === 4'd3);
    end
    check("hold_cycles", hold_ok, 20);

    // Reset mid-VALID with line 3 still held.
    b_n = 10'h3F7;
    tick(3);
    check("pre_reset_valid", valid, 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("midreset_valid", valid, 0);
    check("midreset_code", code, 0);
    wait_valid("rearm3", 6, 4'd3);
    ack_and_release();

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
